// File: rtl/int_to_fp_arbiter.sv
// Round-robin arbiter sharing one combinational int64 -> IEEE-754 double converter
// between two requesters, with a registered, id-tagged result slot and handoff counter.

module int_to_fp (
  input  logic [63:0] a,
  output logic [63:0] f
);
  logic        sign;
  logic [63:0] mag;
  logic [5:0]  msb;
  logic [63:0] norm;
  logic [62:0] exp_mant;
  logic        rnd;
  logic [62:0] sum;

  always_comb begin
    sign = a[63];
    // Two's-complement negate; INT64_MIN maps to 2^63, which is the correct magnitude.
    mag  = sign ? (~a + 64'd1) : a;
    msb  = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (mag[i]) msb = 6'(i);
    end
    norm     = mag << (6'd63 - msb);
    exp_mant = {11'd1023 + {5'd0, msb}, norm[62:11]};
    // Round-to-nearest-even; a mantissa carry ripples into the exponent field.
    rnd      = norm[10] && ((|norm[9:0]) || norm[11]);
    sum      = exp_mant + {62'd0, rnd};
    f        = (mag == '0) ? '0 : {sign, sum};
  end
endmodule

module int_to_fp_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [63:0]      req0_int,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [63:0]      req1_int,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [63:0]      res_fp,
  output logic             res_id,
  input  logic             res_ready,
  output logic [CNT_W-1:0] conv_count
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        slot_free;
  logic        gnt0, gnt1;
  logic        accept;
  logic [63:0] conv_in;
  logic [63:0] conv_out;

  assign res_valid = (state == FULL);
  assign slot_free = !res_valid || res_ready;

  always_comb begin
    gnt0 = slot_free && req0_valid && (!req1_valid || last_grant);
    gnt1 = slot_free && req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 || gnt1;
  assign conv_in    = gnt1 ? req1_int : req0_int;

  int_to_fp u_conv (
    .a (conv_in),
    .f (conv_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (res_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      res_fp     <= '0;
      res_id     <= 1'b0;
      conv_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        res_fp     <= conv_out;
        res_id     <= gnt1;
        last_grant <= gnt1;
      end
      if (res_valid && res_ready) conv_count <= conv_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_int_to_fp_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed results at grant time,
// a negedge monitor pops and compares on every handoff.

module tb_int_to_fp_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [63:0] req0_int, req1_int;
  logic        req0_ready, req1_ready;
  logic        res_valid;
  logic [63:0] res_fp;
  logic        res_id;
  logic        res_ready;
  logic [3:0]  conv_count;

  int total = 0;
  int bad   = 0;
  logic [64:0] sb[$];

  int_to_fp_arbiter #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_int   (req0_int),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_int   (req1_int),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_fp     (res_fp),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got id=%0d fp=%h want nothing", res_id, res_fp);
      end else begin
        chk("result", {res_id, res_fp}, sb.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // g: expected granted requester (-1 = none); cnt: expected conv_count (-1 = skip)
  task automatic expect_grant(input int g, input logic [63:0] fp, input int cnt);
    @(negedge clk);
    chk("req0_ready", {64'd0, req0_ready}, {64'd0, (g == 0)});
    chk("req1_ready", {64'd0, req1_ready}, {64'd0, (g == 1)});
    if (g >= 0) sb.push_back({g[0], fp});
    if (cnt >= 0) chk("conv_count", {61'd0, conv_count}, 65'(cnt));
    next_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_int = '0;
    req1_int = '0;
    res_ready = 1'b0;
    sb.delete();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_valid", {64'd0, res_valid}, 65'd0);
    chk("rst_fp", {1'b0, res_fp}, 65'd0);
    chk("rst_id", {64'd0, res_id}, 65'd0);
    chk("rst_cnt", {61'd0, conv_count}, 65'd0);
    next_cycle();

    // single conversion, latency and counter
    req0_valid = 1'b1; req0_int = 64'd1; res_ready = 1'b1;
    expect_grant(0, 64'h3FF0000000000000, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid", {64'd0, res_valid}, 65'd1);
    chk("lat_cnt", {61'd0, conv_count}, 65'd0);
    next_cycle();
    @(negedge clk);
    chk("cnt_one", {61'd0, conv_count}, 65'd1);
    chk("drained", {64'd0, res_valid}, 65'd0);
    next_cycle();

    // both valid: alternating grants starting at requester 0
    do_reset();
    req0_valid = 1'b1; req0_int = 64'h7FFFFFFFFFFFFFFF;
    req1_valid = 1'b1; req1_int = 64'hFFFFFFFFFFFFFFFF;
    res_ready = 1'b1;
    expect_grant(0, 64'h43E0000000000000, -1);
    expect_grant(1, 64'hBFF0000000000000, -1);
    expect_grant(0, 64'h43E0000000000000, -1);
    expect_grant(1, 64'hBFF0000000000000, -1);
    idle(3);

    // backpressure, then drain+accept with no bubble
    do_reset();
    req1_valid = 1'b1; req1_int = 64'h0020000000000003;
    expect_grant(1, 64'h4340000000000002, -1);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_int = 64'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {64'd0, res_valid}, 65'd1);
      chk("bp_fp", {1'b0, res_fp}, {1'b0, 64'h4340000000000002});
      chk("bp_id", {64'd0, res_id}, 65'd1);
      chk("bp_r0", {64'd0, req0_ready}, 65'd0);
      chk("bp_r1", {64'd0, req1_ready}, 65'd0);
      next_cycle();
    end
    res_ready = 1'b1;
    expect_grant(0, 64'h4014000000000000, -1);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("nobubble_valid", {64'd0, res_valid}, 65'd1);
    next_cycle();
    idle(2);

    // streaming at full rate
    do_reset();
    res_ready = 1'b1;
    req0_valid = 1'b1;
    req0_int = 64'h0;                expect_grant(0, 64'h0000000000000000, -1);
    req0_int = 64'h0010000000000000; expect_grant(0, 64'h4330000000000000, -1);
    req0_int = 64'h8000000000000000; expect_grant(0, 64'hC3E0000000000000, -1);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("stream_cnt2", {61'd0, conv_count}, 65'd2);
    next_cycle();
    @(negedge clk);
    chk("stream_cnt3", {61'd0, conv_count}, 65'd3);
    next_cycle();

    // reset while a result is held under backpressure
    do_reset();
    req0_valid = 1'b1; req0_int = 64'd1;
    expect_grant(0, 64'h3FF0000000000000, -1);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {64'd0, res_valid}, 65'd1);
    next_cycle();
    rst_n = 1'b0;
    sb.delete();
    req0_valid = 1'b1; req0_int = 64'd2;
    req1_valid = 1'b1; req1_int = 64'd3;
    next_cycle();
    @(negedge clk);
    chk("mid_rst_valid", {64'd0, res_valid}, 65'd0);
    chk("mid_rst_fp", {1'b0, res_fp}, 65'd0);
    chk("mid_rst_cnt", {61'd0, conv_count}, 65'd0);
    next_cycle();
    rst_n = 1'b1;
    res_ready = 1'b1;
    expect_grant(0, 64'h4000000000000000, -1);
    expect_grant(1, 64'h4008000000000000, -1);
    idle(3);

    // 4-bit counter wrap over 17 handoffs
    do_reset();
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_int = 64'd1;
    for (int i = 0; i < 17; i++)
      expect_grant(0, 64'h3FF0000000000000, (i == 0) ? 0 : ((i - 1) % 16));
    req0_valid = 1'b0;
    @(negedge clk);
    chk("wrap_cnt16", {61'd0, conv_count}, 65'd0);
    next_cycle();
    @(negedge clk);
    chk("wrap_cnt17", {61'd0, conv_count}, 65'd1);
    next_cycle();
    idle(2);

    chk("sb_empty", 65'(sb.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_to_fp_arbiter.md
Name: int_to_fp_arbiter

Overview:
Shares one combinational int_to_fp converter between two requesters (64-bit signed integer to IEEE-754 double, round-to-nearest-even).
- Arbitration: round-robin.
- Handshake: valid/ready on both sides.
- Output: one registered result slot tagged with the source id, plus a completed-conversion counter.
- Placement: between the integer ALU issue paths and the FP writeback stage of the FPCalculator datapath.

Parameters:
CNT_W, 16, width of the completed-conversion counter conv_count.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
req0_valid  input  1  requester 0 presents an integer
req0_int  input  64  requester 0 signed integer operand
req0_ready  output  1  requester 0 operand accepted this cycle when high with req0_valid
req1_valid  input  1  requester 1 presents an integer
req1_int  input  64  requester 1 signed integer operand
req1_ready  output  1  requester 1 operand accepted this cycle when high with req1_valid
res_valid  output  1  result slot holds a valid result
res_fp  output  64  double-precision result
res_id  output  1  source of res_fp (0 = requester 0, 1 = requester 1)
res_ready  input  1  consumer takes the result this cycle when high with res_valid
conv_count  output  CNT_W  number of results handed off (res_valid && res_ready), wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n low at a rising edge):
  - res_valid=0, res_fp=0, res_id=0, conv_count=0.
  - Round-robin pointer last_grant=1, so requester 0 has priority first.
  - Any held result is discarded. No handoff is counted in the reset cycle.
- slot_free = !res_valid || res_ready (combinational). The slot can be refilled in the same cycle it drains.
- Grant (combinational, evaluated only when slot_free):
  - Only one requester valid: grant it.
  - Both valid: grant the requester != last_grant.
  - None valid: no grant.
  - reqN_ready = slot_free && grant==N. At most one ready is high per cycle.
  - Ready may depend on the valids and res_ready. Requesters must not make valid depend on ready.
- Accept (reqN_valid && reqN_ready at a rising edge):
  - res_fp <= int_to_fp(reqN_int) through a single instance of the int_to_fp module.
  - res_id <= N, res_valid <= 1, last_grant <= N.
  - Latency: exactly 1 cycle from accept edge to res_valid high.
  - Sustained throughput: 1 result/cycle when res_ready is held high.
- Drain without accept: res_valid && res_ready with no accept clears res_valid to 0. res_fp and res_id keep their last values.
- Backpressure: while res_valid && !res_ready, res_fp, res_id and res_valid hold stable and both readies stay 0.
- Counter: conv_count increments by 1 on every edge with res_valid && res_ready, including cycles that also accept. It wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- Requester-side rule: a requester holding valid without ready must keep its operand stable. The arbiter does not check this.
- Effective states: EMPTY (res_valid=0) and FULL (res_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on drain+accept or on stall.
  - FULL -> EMPTY on drain without accept.

Test Plan:
- Reset, then req0_valid=1, req0_int=1, res_ready=1 -> req0_ready=1 in that cycle; next cycle res_valid=1, res_fp=0x3FF0000000000000, res_id=0; conv_count=1 one cycle later.
- Both valid simultaneously after reset (req0_int=0x7FFFFFFFFFFFFFFF, req1_int=-1), res_ready=1 -> first result 0x43E0000000000000 with id 0, then 0xBFF0000000000000 with id 1 on consecutive cycles. If both stay valid, grants alternate 0,1,0,1.
- Backpressure with res_ready=0: accept req1_int=0x20000000000003 -> res_fp=0x4340000000000002, id 1. res_fp, res_id and res_valid stay stable for 5 cycles with req0_ready=req1_ready=0 and req0 valid. Raising res_ready drains the result and accepts req0 in the same cycle; no bubble.
- Streaming with res_ready=1: req0 presents 0, 0x0010000000000000, 0x8000000000000000 back-to-back -> results 0x0, 0x4330000000000000, 0xC3E0000000000000 on 3 consecutive cycles; conv_count=3.
- Reset mid-operation: pull rst_n low while res_valid=1 and res_ready=0 -> next cycle res_valid=0, res_fp=0, conv_count=0, no count for the dropped result. The first grant after reset goes to requester 0 even if both are valid.
- With CNT_W=4: complete 17 handoffs -> conv_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
